// File: rtl/piano_pkg.sv
// Shared types for the note link: frame layout, FSM states and the frame builder.
package piano_pkg;

    localparam int NOTE_W  = 8;
    localparam int FRAME_W = 32;
    localparam logic [NOTE_W-1:0] FRAME_PAD = 8'h00;

    typedef struct packed {
        logic [NOTE_W-1:0] pad;
        logic [NOTE_W-1:0] n3;
        logic [NOTE_W-1:0] n2;
        logic [NOTE_W-1:0] n1;
    } note_frame_t;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} spi_tx_state_t;

    function automatic note_frame_t build_frame(input logic [NOTE_W-1:0] n1,
                                                input logic [NOTE_W-1:0] n2,
                                                input logic [NOTE_W-1:0] n3);
        note_frame_t f;
        f.pad = FRAME_PAD;
        f.n3  = n3;
        f.n2  = n2;
        f.n1  = n1;
        return f;
    endfunction

endpackage

// File: rtl/spi_note_master_if.sv
// Note-source handshake plus SPI pins of the note link transmitter.
// cs_n exists only when SPI_CS_EN is defined.
interface spi_note_master_if;
    import piano_pkg::*;

    logic [NOTE_W-1:0] note1;
    logic [NOTE_W-1:0] note2;
    logic [NOTE_W-1:0] note3;
    logic              in_valid;
    logic              in_ready;
    logic              busy;
    logic              sck;
    logic              sdo;
`ifdef SPI_CS_EN
    logic              cs_n;
`endif

    modport master (
        input  note1, note2, note3, in_valid,
        output in_ready, busy, sck, sdo
`ifdef SPI_CS_EN
        , output cs_n
`endif
    );

    modport slave (
        output note1, note2, note3, in_valid,
        input  in_ready, busy, sck, sdo
`ifdef SPI_CS_EN
        , input cs_n
`endif
    );

endinterface

// File: rtl/spi_note_master_sck_gen.sv
// SPI mode-0 clock divider: CLK_DIV clks low then CLK_DIV clks high while enabled.
// rise/fall are one-clk strobes asserted on the clk edge at which sck toggles.
module spi_sck_gen #(
    parameter int CLK_DIV = 20
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic sck,
    output logic rise,
    output logic fall
);
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             wrap;

    assign wrap = en && (div_cnt == DIV_LAST);
    assign rise = wrap && !sck;
    assign fall = wrap && sck;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            sck     <= 1'b0;
        end else if (!en) begin
            div_cnt <= '0;
            sck     <= 1'b0;
        end else if (wrap) begin
            div_cnt <= '0;
            sck     <= !sck;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_note_master.sv
// Note link transmitter: packs three notes into a 32-bit SPI mode-0 frame, MSB first.
// Optional SPI_CS_EN macro adds an active-low chip select framing each transfer.
module spi_note_master
    import piano_pkg::*;
#(
    parameter int CLK_DIV    = 20,
    parameter int GAP_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    spi_note_master_if.master bus
);
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [5:0] LAST_BIT = 6'd31;

    spi_tx_state_t    state;
    note_frame_t      shreg;
    logic [5:0]       bit_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             in_ready_r;
    logic             busy_r;
    logic             rise;
    logic             fall;

`ifdef SPI_CS_EN
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    logic             cs_n_r;
    logic [DIV_W-1:0] hold_cnt;
    assign bus.cs_n = cs_n_r;
`endif

    spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (state == SHIFT),
        .sck     (bus.sck),
        .rise    (rise),
        .fall    (fall)
    );

    // The register drains to zero after 32 shifts, so sdo idles low without extra logic.
    assign bus.sdo      = shreg[FRAME_W-1];
    assign bus.in_ready = in_ready_r;
    assign bus.busy     = busy_r;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b0;
`ifdef SPI_CS_EN
            cs_n_r     <= 1'b1;
            hold_cnt   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        shreg      <= build_frame(bus.note1, bus.note2, bus.note3);
                        bit_cnt    <= '0;
                        state      <= SHIFT;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
`ifdef SPI_CS_EN
                        cs_n_r     <= 1'b0;
`endif
                    end
                end
                SHIFT: begin
                    if (fall) begin
                        shreg   <= note_frame_t'({shreg[FRAME_W-2:0], 1'b0});
                        bit_cnt <= bit_cnt + 6'd1;
                        if (bit_cnt == LAST_BIT) begin
`ifdef SPI_CS_EN
                            state <= GAP;
`else
                            if (GAP_CYCLES == 0) begin
                                state      <= IDLE;
                                in_ready_r <= 1'b1;
                                busy_r     <= 1'b0;
                            end else begin
                                state <= GAP;
                            end
`endif
                        end
                    end
                end
                GAP: begin
                    // With chip select, GAP first holds cs_n low for one sck half-period.
`ifdef SPI_CS_EN
                    if (!cs_n_r) begin
                        if (hold_cnt == DIV_LAST) begin
                            hold_cnt <= '0;
                            cs_n_r   <= 1'b1;
                            if (GAP_CYCLES == 0) begin
                                state      <= IDLE;
                                in_ready_r <= 1'b1;
                                busy_r     <= 1'b0;
                            end
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end else
`endif
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt    <= '0;
                        state      <= IDLE;
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always @(posedge clk) begin
        if (reset_n && rise) assert (state == SHIFT && bit_cnt < 6'd32);
    end

endmodule
